// File: rtl/servo_cmd_sequencer.sv
// Servo command sequencer: parses FF/CH/POS/CHK packets from the UART, keeps a target
// per channel, slews outputs toward targets once per servo frame, and centres on link loss.

module servo_slew_lane #(
    parameter int STEP   = 4,
    parameter int CENTER = 128
) (
    input  logic       clk50mhz,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_pos,
    input  logic       force_ctr,
    output logic [7:0] cur
);
    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [7:0] CTR8  = 8'(CENTER);

    logic [7:0] tgt;
    logic [8:0] up9, dn9;
    logic [7:0] slew_nxt;

    // 9-bit intermediates: up9 cannot wrap past 255, dn9[8] flags an underflow
    always_comb begin
        up9      = {1'b0, cur} + STEP9;
        dn9      = {1'b0, cur} - STEP9;
        slew_nxt = cur;
        if (cur < tgt)
            slew_nxt = (up9 > {1'b0, tgt}) ? tgt : up9[7:0];
        else if (cur > tgt)
            slew_nxt = (dn9[8] || (dn9 < {1'b0, tgt})) ? tgt : dn9[7:0];
    end

    // Slew reads the registered target, so a same-cycle commit only affects the next frame
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            tgt <= CTR8;
            cur <= CTR8;
        end else begin
            if (tick)
                cur <= slew_nxt;
            if (load)
                tgt <= load_pos;
            else if (force_ctr)
                tgt <= CTR8;
        end
    end
endmodule

module servo_cmd_sequencer #(
    parameter int CLK_FREQ       = 50000000,
    parameter int FRAME_TICKS    = 1000000,
    parameter int STEP           = 4,
    parameter int TIMEOUT_FRAMES = 50,
    parameter int CENTER         = 128
) (
    input  logic       clk50mhz,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pos_a,
    output logic [7:0] pos_b,
    output logic       frame_tick,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic       failsafe
);
    localparam int NUM_CH = 2;
    localparam int FW     = $clog2(FRAME_TICKS + 1);
    localparam int TW     = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [TW-1:0] TOUT_MAX   = TW'(TIMEOUT_FRAMES);

    if (STEP < 1 || STEP > 127 || FRAME_TICKS > CLK_FREQ) begin : g_param_check
        $error("servo_cmd_sequencer: STEP out of range or frame longer than one second");
    end

    typedef enum logic [1:0] {S_SYNC, S_CH, S_POS, S_CHK} state_t;
    typedef struct packed {
        logic       ch;
        logic [7:0] pos;
    } cmd_t;

    state_t                  state, state_nxt;
    cmd_t                    cmd, cmd_nxt;
    logic                    commit, reject;
    logic [FW-1:0]           frame_cnt;
    logic [TW-1:0]           tout_cnt, tout_inc;
    logic                    tout_hit;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH-1:0][7:0]  cur;

    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            state   <= S_SYNC;
            cmd     <= '0;
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cmd     <= cmd_nxt;
            pkt_ok  <= commit;
            pkt_err <= reject;
        end
    end

    // An 0xFF anywhere but CHK restarts a packet; in CHK it is just a (likely bad) checksum
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        commit    = 1'b0;
        reject    = 1'b0;
        if (rx_valid) begin
            case (state)
                S_SYNC: begin
                    if (rx_data == 8'hFF)
                        state_nxt = S_CH;
                end
                S_CH: begin
                    if (rx_data == 8'hFF) begin
                        state_nxt = S_CH;
                    end else if (rx_data <= 8'd1) begin
                        cmd_nxt.ch = rx_data[0];
                        state_nxt  = S_POS;
                    end else begin
                        reject    = 1'b1;
                        state_nxt = S_SYNC;
                    end
                end
                S_POS: begin
                    if (rx_data == 8'hFF) begin
                        reject    = 1'b1;
                        state_nxt = S_CH;
                    end else begin
                        cmd_nxt.pos = rx_data;
                        state_nxt   = S_CHK;
                    end
                end
                S_CHK: begin
                    if (rx_data == ({7'b0, cmd.ch} ^ cmd.pos))
                        commit = 1'b1;
                    else
                        reject = 1'b1;
                    state_nxt = S_SYNC;
                end
                default: state_nxt = S_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else if (frame_cnt == FRAME_LAST) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b1;
        end else begin
            frame_cnt  <= frame_cnt + FW'(1);
            frame_tick <= 1'b0;
        end
    end

    assign tout_inc = (tout_cnt == TOUT_MAX) ? tout_cnt : tout_cnt + TW'(1);
    // A commit in a tick cycle keeps the link alive and suppresses the forced centring
    assign tout_hit = frame_tick && !commit && (tout_inc == TOUT_MAX);

    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            tout_cnt <= '0;
            failsafe <= 1'b0;
        end else if (commit) begin
            tout_cnt <= '0;
            failsafe <= 1'b0;
        end else if (frame_tick) begin
            tout_cnt <= tout_inc;
            if (tout_inc == TOUT_MAX)
                failsafe <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        assign load[i] = commit && (cmd.ch == 1'(i));
        servo_slew_lane #(
            .STEP   (STEP),
            .CENTER (CENTER)
        ) u_lane (
            .clk50mhz  (clk50mhz),
            .rst       (rst),
            .tick      (frame_tick),
            .load      (load[i]),
            .load_pos  (cmd.pos),
            .force_ctr (tout_hit),
            .cur       (cur[i])
        );
    end

    assign pos_a = cur[0];
    assign pos_b = cur[1];
endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Bench for servo_cmd_sequencer: packet events and per-frame positions are scoreboarded
// through queues filled at stimulus time and drained as the DUT reports them.

module tb_servo_cmd_sequencer;
    localparam int FT     = 40;
    localparam int STEP   = 4;
    localparam int TO     = 50;
    localparam int EV_OK  = 1;
    localparam int EV_ERR = 2;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       fs;
    } pos_t;

    logic       clk50mhz = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] pos_a, pos_b;
    logic       frame_tick, pkt_ok, pkt_err, failsafe;

    int   exp_ev[$];
    int   obs_ev[$];
    pos_t exp_pos[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   rst_cyc = 0;
    int   tick_cyc = 0;

    servo_cmd_sequencer #(
        .FRAME_TICKS    (FT),
        .STEP           (STEP),
        .TIMEOUT_FRAMES (TO),
        .CENTER         (128)
    ) dut (
        .clk50mhz   (clk50mhz),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .pos_a      (pos_a),
        .pos_b      (pos_b),
        .frame_tick (frame_tick),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .failsafe   (failsafe)
    );

    always #10 clk50mhz = ~clk50mhz;
    always @(posedge clk50mhz) cyc <= cyc + 1;

    always @(negedge clk50mhz) begin
        if (pkt_ok)  obs_ev.push_back(EV_OK);
        if (pkt_err) obs_ev.push_back(EV_ERR);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic pos_t mk(input int a, input int b, input bit fs);
        pos_t p;
        p.a  = a[7:0];
        p.b  = b[7:0];
        p.fs = fs;
        return p;
    endfunction

    task automatic do_reset();
        @(negedge clk50mhz);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk50mhz);
        rst_cyc = cyc;
        rst     = 1'b0;
        obs_ev.delete();
        exp_ev.delete();
        exp_pos.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk50mhz);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk50mhz);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
    endtask

    task automatic wait_events(input int n);
        for (int i = 0; i < 20 && obs_ev.size() < n; i++) @(negedge clk50mhz);
    endtask

    // Leaves the bench one negedge past the tick, after the slew edge has landed
    task automatic wait_frame(output bit got);
        got = 1'b0;
        for (int i = 0; i < 2 * FT && !got; i++) begin
            @(negedge clk50mhz);
            if (frame_tick) begin
                got      = 1'b1;
                tick_cyc = cyc;
            end
        end
        if (got) @(negedge clk50mhz);
    endtask

    task automatic test_reset();
        pos_t p;
        bit   got;
        int   prev;
        do_reset();
        n_chk++;
        if ({pos_a, pos_b, failsafe, frame_tick, pkt_ok, pkt_err} !== {8'd128, 8'd128, 4'b0000})
            $display("FAIL reset_state: got a=%0d b=%0d fs=%0b tick=%0b ok=%0b err=%0b expected 128 128 0 0 0 0",
                     pos_a, pos_b, failsafe, frame_tick, pkt_ok, pkt_err);
        else n_pass++;
        send_byte(8'h50);
        send_byte(8'h00);
        for (int k = 0; k < 3; k++) exp_pos.push_back(mk(128, 128, 1'b0));
        prev = rst_cyc;
        while (exp_pos.size() > 0) begin
            p = exp_pos.pop_front();
            wait_frame(got);
            n_chk++;
            if (!got) $display("FAIL reset_idle_pos: no frame_tick within %0d cycles", 2 * FT);
            else if ({pos_a, pos_b, failsafe} !== p)
                $display("FAIL reset_idle_pos: got %0d/%0d/%0b expected %0d/%0d/%0b", pos_a, pos_b, failsafe, p.a, p.b, p.fs);
            else n_pass++;
            n_chk++;
            if (tick_cyc - prev !== FT) $display("FAIL frame_period: got %0d expected %0d", tick_cyc - prev, FT);
            else n_pass++;
            prev = tick_cyc;
        end
        n_chk++;
        if (obs_ev.size() !== 0) $display("FAIL sync_garbage: got %0d packet events expected 0", obs_ev.size());
        else n_pass++;
    endtask

    task automatic test_slew_up();
        pos_t p;
        bit   got;
        int   e, o, a;
        do_reset();
        send_pkt(8'hFF, 8'h00, 8'hC8, 8'hC8);
        exp_ev.push_back(EV_OK);
        for (int k = 1; k <= 19; k++) begin
            a = 128 + STEP * k;
            exp_pos.push_back(mk((a > 200) ? 200 : a, 128, 1'b0));
        end
        wait_events(exp_ev.size());
        while (exp_ev.size() > 0) begin
            e = exp_ev.pop_front();
            o = 0;
            if (obs_ev.size() > 0) o = obs_ev.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL slew_up_event: got %0d expected %0d", o, e);
            else n_pass++;
        end
        while (exp_pos.size() > 0) begin
            p = exp_pos.pop_front();
            wait_frame(got);
            n_chk++;
            if (!got) $display("FAIL slew_up_pos: no frame_tick within %0d cycles", 2 * FT);
            else if ({pos_a, pos_b, failsafe} !== p)
                $display("FAIL slew_up_pos: got %0d/%0d/%0b expected %0d/%0d/%0b", pos_a, pos_b, failsafe, p.a, p.b, p.fs);
            else n_pass++;
        end
    endtask

    task automatic test_slew_down();
        pos_t p;
        bit   got;
        int   e, o, b;
        do_reset();
        send_pkt(8'hFF, 8'h01, 8'h02, 8'h03);
        exp_ev.push_back(EV_OK);
        b = 128;
        for (int k = 1; k <= 33; k++) begin
            b = (b > 2 + STEP) ? b - STEP : 2;
            exp_pos.push_back(mk(128, b, 1'b0));
        end
        wait_events(exp_ev.size());
        while (exp_ev.size() > 0) begin
            e = exp_ev.pop_front();
            o = 0;
            if (obs_ev.size() > 0) o = obs_ev.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL slew_down_event: got %0d expected %0d", o, e);
            else n_pass++;
        end
        while (exp_pos.size() > 0) begin
            p = exp_pos.pop_front();
            wait_frame(got);
            n_chk++;
            if (!got) $display("FAIL slew_down_pos: no frame_tick within %0d cycles", 2 * FT);
            else if ({pos_a, pos_b, failsafe} !== p)
                $display("FAIL slew_down_pos: got %0d/%0d/%0b expected %0d/%0d/%0b", pos_a, pos_b, failsafe, p.a, p.b, p.fs);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        pos_t p;
        bit   got;
        int   e, o;
        do_reset();
        send_pkt(8'hFF, 8'h00, 8'h50, 8'h51);
        send_byte(8'hFF);
        send_byte(8'h05);
        exp_ev.push_back(EV_ERR);
        exp_ev.push_back(EV_ERR);
        exp_pos.push_back(mk(128, 128, 1'b0));
        wait_events(exp_ev.size());
        while (exp_ev.size() > 0) begin
            e = exp_ev.pop_front();
            o = 0;
            if (obs_ev.size() > 0) o = obs_ev.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL bad_pkt_event: got %0d expected %0d", o, e);
            else n_pass++;
        end
        while (exp_pos.size() > 0) begin
            p = exp_pos.pop_front();
            wait_frame(got);
            n_chk++;
            if (!got) $display("FAIL bad_pkt_pos: no frame_tick within %0d cycles", 2 * FT);
            else if ({pos_a, pos_b, failsafe} !== p)
                $display("FAIL bad_pkt_pos: got %0d/%0d/%0b expected %0d/%0d/%0b", pos_a, pos_b, failsafe, p.a, p.b, p.fs);
            else n_pass++;
        end
        // 0xFF in the POS slot rejects and resyncs, so 00 50 50 completes a packet
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h50); send_byte(8'h50);
        exp_ev.push_back(EV_ERR);
        exp_ev.push_back(EV_OK);
        exp_pos.push_back(mk(124, 128, 1'b0));
        exp_pos.push_back(mk(120, 128, 1'b0));
        wait_events(exp_ev.size());
        while (exp_ev.size() > 0) begin
            e = exp_ev.pop_front();
            o = 0;
            if (obs_ev.size() > 0) o = obs_ev.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL resync_event: got %0d expected %0d", o, e);
            else n_pass++;
        end
        while (exp_pos.size() > 0) begin
            p = exp_pos.pop_front();
            wait_frame(got);
            n_chk++;
            if (!got) $display("FAIL resync_pos: no frame_tick within %0d cycles", 2 * FT);
            else if ({pos_a, pos_b, failsafe} !== p)
                $display("FAIL resync_pos: got %0d/%0d/%0b expected %0d/%0d/%0b", pos_a, pos_b, failsafe, p.a, p.b, p.fs);
            else n_pass++;
        end
    endtask

    task automatic test_failsafe();
        pos_t p;
        bit   got;
        int   e, o, a;
        do_reset();
        send_pkt(8'hFF, 8'h00, 8'hC8, 8'hC8);
        exp_ev.push_back(EV_OK);
        for (int k = 1; k <= 70; k++) begin
            if (k <= 18)      a = 128 + STEP * k;
            else if (k <= TO) a = 200;
            else              a = 200 - STEP * (k - TO);
            if (a < 128) a = 128;
            exp_pos.push_back(mk(a, 128, k >= TO));
        end
        wait_events(exp_ev.size());
        while (exp_ev.size() > 0) begin
            e = exp_ev.pop_front();
            o = 0;
            if (obs_ev.size() > 0) o = obs_ev.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL failsafe_cmd_event: got %0d expected %0d", o, e);
            else n_pass++;
        end
        while (exp_pos.size() > 0) begin
            p = exp_pos.pop_front();
            wait_frame(got);
            n_chk++;
            if (!got) $display("FAIL failsafe_pos: no frame_tick within %0d cycles", 2 * FT);
            else if ({pos_a, pos_b, failsafe} !== p)
                $display("FAIL failsafe_pos: got %0d/%0d/%0b expected %0d/%0d/%0b", pos_a, pos_b, failsafe, p.a, p.b, p.fs);
            else n_pass++;
        end
        send_pkt(8'hFF, 8'h01, 8'h64, 8'h65);
        exp_ev.push_back(EV_OK);
        exp_pos.push_back(mk(128, 124, 1'b0));
        wait_events(exp_ev.size());
        while (exp_ev.size() > 0) begin
            e = exp_ev.pop_front();
            o = 0;
            if (obs_ev.size() > 0) o = obs_ev.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL recover_event: got %0d expected %0d", o, e);
            else n_pass++;
        end
        n_chk++;
        if (failsafe !== 1'b0) $display("FAIL failsafe_clear: got %0b expected 0", failsafe);
        else n_pass++;
        while (exp_pos.size() > 0) begin
            p = exp_pos.pop_front();
            wait_frame(got);
            n_chk++;
            if (!got) $display("FAIL recover_pos: no frame_tick within %0d cycles", 2 * FT);
            else if ({pos_a, pos_b, failsafe} !== p)
                $display("FAIL recover_pos: got %0d/%0d/%0b expected %0d/%0d/%0b", pos_a, pos_b, failsafe, p.a, p.b, p.fs);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        pos_t p;
        bit   got;
        int   e, o;
        do_reset();
        send_pkt(8'hFF, 8'h00, 8'hC8, 8'hC8);
        exp_pos.push_back(mk(132, 128, 1'b0));
        exp_pos.push_back(mk(136, 128, 1'b0));
        while (exp_pos.size() > 0) begin
            p = exp_pos.pop_front();
            wait_frame(got);
            n_chk++;
            if (!got) $display("FAIL pre_reset_pos: no frame_tick within %0d cycles", 2 * FT);
            else if ({pos_a, pos_b, failsafe} !== p)
                $display("FAIL pre_reset_pos: got %0d/%0d/%0b expected %0d/%0d/%0b", pos_a, pos_b, failsafe, p.a, p.b, p.fs);
            else n_pass++;
        end
        send_byte(8'hFF);
        send_byte(8'h00);
        do_reset();
        n_chk++;
        if ({pos_a, pos_b, failsafe, frame_tick, pkt_ok, pkt_err} !== {8'd128, 8'd128, 4'b0000})
            $display("FAIL mid_reset_state: got a=%0d b=%0d fs=%0b tick=%0b ok=%0b err=%0b expected 128 128 0 0 0 0",
                     pos_a, pos_b, failsafe, frame_tick, pkt_ok, pkt_err);
        else n_pass++;
        send_byte(8'h50);
        send_pkt(8'hFF, 8'h01, 8'h96, 8'h97);
        exp_ev.push_back(EV_OK);
        for (int k = 1; k <= 3; k++) exp_pos.push_back(mk(128, 128 + STEP * k, 1'b0));
        wait_events(exp_ev.size() + 1);
        while (exp_ev.size() > 0) begin
            e = exp_ev.pop_front();
            o = 0;
            if (obs_ev.size() > 0) o = obs_ev.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL post_reset_event: got %0d expected %0d", o, e);
            else n_pass++;
        end
        n_chk++;
        if (obs_ev.size() !== 0) $display("FAIL post_reset_extra_events: got %0d expected 0", obs_ev.size());
        else n_pass++;
        while (exp_pos.size() > 0) begin
            p = exp_pos.pop_front();
            wait_frame(got);
            n_chk++;
            if (!got) $display("FAIL post_reset_pos: no frame_tick within %0d cycles", 2 * FT);
            else if ({pos_a, pos_b, failsafe} !== p)
                $display("FAIL post_reset_pos: got %0d/%0d/%0b expected %0d/%0d/%0b", pos_a, pos_b, failsafe, p.a, p.b, p.fs);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_slew_up();
        test_slew_down();
        test_errors();
        test_failsafe();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/servo_cmd_sequencer.md
Name: servo_cmd_sequencer

Overview:
- Sits between the 9600-baud UART byte receiver and the two servo PWM generators.
- Parses framed, checksummed position packets and keeps a target position per channel.
- Slews each channel's output position toward its target at a bounded rate, once per 20 ms servo frame.
- Forces both channels to centre when valid packets stop arriving (link-loss failsafe).

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- FRAME_TICKS, 1000000, clock cycles per slew update (one 20 ms servo frame).
- STEP, 4, maximum position change per frame per channel (1..127).
- TIMEOUT_FRAMES, 50, frames without a valid packet before failsafe engages (1 s).
- CENTER, 128, failsafe and reset position.

Ports:
- clk50mhz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received UART byte; valid only when rx_valid=1.
- rx_valid  in  1  single-cycle strobe, one per received byte.
- pos_a  out  8  slewed position for channel 0, to PWM generator A.
- pos_b  out  8  slewed position for channel 1, to PWM generator B.
- frame_tick  out  1  single-cycle pulse on every slew update.
- pkt_ok  out  1  single-cycle pulse when a packet is committed.
- pkt_err  out  1  single-cycle pulse when a packet is rejected.
- failsafe  out  1  high while the timeout failsafe is active.

Behaviour:
- Reset (rst=1 at a clock edge; the clock is the only one in the block, reset is synchronous active-high):
  - pos_a, pos_b, tgt_a, tgt_b = CENTER.
  - frame_tick, pkt_ok, pkt_err, failsafe = 0.
  - FSM = SYNC; frame counter = 0; timeout counter = 0.
  - Any packet in progress is discarded.
- Packet format: 0xFF sync, then CH (0 or 1), then POS (0..254), then CHK = CH XOR POS.
- FSM states: SYNC, CH, POS, CHK. Transitions occur only on cycles with rx_valid=1.
  - SYNC: byte 0xFF -> CH; any other byte is ignored and the state stays SYNC (no error).
  - CH: 0xFF -> stay in CH (resync); byte <= 1 -> latch channel, go to POS; otherwise pulse pkt_err, go to SYNC.
  - POS: 0xFF -> pulse pkt_err, go to CH (treated as a new sync); otherwise latch position, go to CHK.
  - CHK: byte equals CH^POS -> commit, go to SYNC; otherwise pulse pkt_err, go to SYNC.
- Commit:
  - The cycle after the CHK byte is accepted, the selected target updates and pkt_ok pulses.
  - The timeout counter clears to 0 and failsafe deasserts in that same cycle.
- Frame counter:
  - Counts 0..FRAME_TICKS-1 and wraps.
  - frame_tick is registered: it is high for exactly the one cycle after the count reaches FRAME_TICKS-1.
- Slew, evaluated in the frame_tick cycle for each channel independently:
  - cur < tgt: cur <= min(cur+STEP, tgt).
  - cur > tgt: cur <= max(cur-STEP, tgt).
  - cur = tgt: hold.
  - Arithmetic uses 9-bit intermediates, so cur+STEP never wraps past 255 and cur-STEP never underflows below 0.
- Timeout and failsafe:
  - On each frame_tick with no commit in that cycle, the timeout counter increments, saturating at TIMEOUT_FRAMES.
  - When the counter reaches TIMEOUT_FRAMES, failsafe is set and both targets are forced to CENTER.
  - Slewing then returns the outputs to CENTER at STEP per frame.
- Simultaneous events:
  - Commit and frame_tick in the same cycle: the commit wins for the timeout counter (cleared) and for the target.
  - The slew in that cycle uses the pre-commit target.
- Bytes are accepted in every cycle, including frame_tick cycles; no byte is dropped.
- Outputs change only on frame_tick cycles or reset, so the PWM generators see at most one position change per 20 ms.
- Latency: a commit becomes visible on pos_x at the next frame_tick, no more than FRAME_TICKS+1 cycles after the CHK byte.

Test Plan:
- Reset, then no bytes for 3 frames -> pos_a = pos_b = 128, failsafe = 0, frame_tick period = 1,000,000 cycles.
- Send FF 00 C8 C8 -> pkt_ok pulses; pos_a steps 132, 136, ... and reaches 200 after 18 frames; pos_b stays at 128.
- Send FF 01 02 03 with STEP=4 -> pos_b steps 124, 120, ..., 4, then 2 (clamped at target, no underflow).
- Send FF 00 50 51 (bad checksum), then FF 00 FF, then FF 05 -> three pkt_err pulses; targets unchanged. The 0xFF arriving in the POS state resyncs, so the following 00 50 50 commits tgt_a = 0x50.
- Set tgt_a = 200, then send no packets for 50 frames -> failsafe rises on the 50th frame_tick; pos_a slews back to 128 at 4 per frame; a valid packet clears failsafe.
- Assert rst mid-packet (after FF 00) and mid-slew -> all outputs return to their reset values next cycle; a following 50 FF 01 96 97 sequence commits tgt_b = 0x96 (the leading 50 is ignored in SYNC).
